ysyx_22041412_lsu_req: RTL

- Memory-stage load/store requester. The pipeline stall controller consumes its `stall_from_mem` output.
- Turns the MEM-stage access into one bus transaction and holds the whole pipeline until that transaction completes.
- Generates byte strobes and shifted write data, and extracts and sign/zero-extends load data.
- Sits between the MEM stage, the stall controller and the data bus.

---
 rtl/ysyx_22041412_lsu_req_pkg.sv | 29 ++
 rtl/ysyx_22041412_lsu_align.sv | 50 +++++
 rtl/ysyx_22041412_lsu_req.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_lsu_req_pkg.sv
// Shared types for the MEM-stage load/store requester.
// Holds the FSM state encoding, the funct3 size codes and the stall bit index of MEM.
// No logic of its own apart from one alignment helper.
package ysyx_22041412_lsu_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam int STALL_MEM = 4;

    function automatic logic misaligned(input logic [2:0] size, input logic [2:0] off);
        case (size[1:0])
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041412_lsu_align.sv
// Byte-lane steering: store strobes and shifted data, and load extract/extend.
// Purely combinational, zero latency.
// No handshake; the caller decides when the results are used.
module ysyx_22041412_lsu_align
    import ysyx_22041412_lsu_req_pkg::*;
#(
    parameter int DW = 64,
    localparam int SW = DW / 8,
    localparam int OW = $clog2(SW)
) (
    input  logic [2:0]    size,
    input  logic [OW-1:0] off,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic [SW-1:0] wstrb,
    output logic [DW-1:0] wdata_sh,
    output logic [DW-1:0] ld_ext
);

    logic [DW-1:0] rsh;
    logic          sgn;

    always_comb begin
        wstrb    = '0;
        ld_ext   = '0;
        wdata_sh = wdata << {off, 3'b000};
        rsh      = rdata >> {off, 3'b000};
        sgn      = ~size[2];
        // Strobes wider than the remaining lanes simply fall off the top.
        case (size[1:0])
            SZ_B: begin
                wstrb  = SW'(1) << off;
                ld_ext = {{(DW-8){sgn & rsh[7]}}, rsh[7:0]};
            end
            SZ_H: begin
                wstrb  = SW'(3) << off;
                ld_ext = {{(DW-16){sgn & rsh[15]}}, rsh[15:0]};
            end
            SZ_W: begin
                wstrb  = SW'(15) << off;
                ld_ext = {{(DW-32){sgn & rsh[31]}}, rsh[31:0]};
            end
            default: begin
                wstrb  = '1;
                ld_ext = rsh;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22041412_lsu_req.sv
// MEM-stage requester: one bus transaction per load/store, pipeline held until the response.
// Request goes out combinationally in the access cycle; result is registered and shown in DONE.
// Stalls while granting/awaiting; DONE waits for stall[4]=0. Optional LSU_MISALIGN_CHK_EN.
module ysyx_22041412_lsu_req
    import ysyx_22041412_lsu_req_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_ren,
    input  logic            mem_wen,
    input  logic [2:0]      mem_size,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [5:0]      stall,
    output logic            stall_from_mem,
    output logic [DW-1:0]   ld_data,
    output logic            ld_valid,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [DW-1:0]   bus_rdata
`ifdef LSU_MISALIGN_CHK_EN
    ,
    output logic            misalign
`endif
);

    localparam int OW = $clog2(DW / 8);

    lsu_state_e state_q, state_d;

    logic            acc, mis, issue;
    logic            we_q, ren_q;
    logic [2:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q, ld_q;

    logic            sel_we;
    logic [2:0]      sel_size;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW/8-1:0] al_wstrb;
    logic [DW-1:0]   al_wdata, al_ld;
    logic            unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};
    assign acc          = mem_valid & (mem_ren | mem_wen);

`ifdef LSU_MISALIGN_CHK_EN
    assign mis      = acc & misaligned(mem_size, mem_addr[2:0]);
    assign misalign = rst & mis;
`else
    assign mis = 1'b0;
`endif

    assign issue = acc & ~mis;

    // IDLE steers straight from the MEM inputs; every later state uses the captured copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_we    = mem_wen;
            sel_size  = mem_size;
            sel_addr  = mem_addr;
            sel_wdata = mem_wdata;
        end else begin
            sel_we    = we_q;
            sel_size  = size_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
        end
    end

    ysyx_22041412_lsu_align #(.DW(DW)) u_align (
        .size     (sel_size),
        .off      (sel_addr[OW-1:0]),
        .wdata    (sel_wdata),
        .rdata    (bus_rdata),
        .wstrb    (al_wstrb),
        .wdata_sh (al_wdata),
        .ld_ext   (al_ld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            ren_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && issue) begin
                we_q    <= mem_wen;
                ren_q   <= mem_ren;
                size_q  <= mem_size;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (state_q == ST_WAIT && bus_rvalid) begin
                ld_q <= al_ld;
            end
        end
    end

    // Outputs are gated by reset so nothing leaks out combinationally while it is held.
    always_comb begin
        state_d        = state_q;
        stall_from_mem = 1'b0;
        ld_data        = '0;
        ld_valid       = 1'b0;
        bus_req        = 1'b0;
        bus_we         = 1'b0;
        bus_addr       = '0;
        bus_wdata      = '0;
        bus_wstrb      = '0;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        stall_from_mem = 1'b1;
                        bus_req        = 1'b1;
                        state_d        = bus_gnt ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    stall_from_mem = 1'b1;
                    bus_req        = 1'b1;
                    if (bus_gnt) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    stall_from_mem = 1'b1;
                    if (bus_rvalid) state_d = ST_DONE;
                end
                ST_DONE: begin
                    ld_valid = ren_q;
                    ld_data  = ld_q;
                    if (!stall[STALL_MEM]) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (bus_req) begin
                bus_we    = sel_we;
                bus_addr  = {sel_addr[AW-1:OW], {OW{1'b0}}};
                bus_wdata = al_wdata;
                bus_wstrb = al_wstrb;
            end
        end
    end

endmodule
